// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   UART boot loader. Receives framed images over an 8N1 serial line and
//   writes them, one word per strobe, into NUM_TGT target memories.
//   Frame: TGT | CNT_LO CNT_HI | N words (DATA_W/8 bytes each, little-endian)
//   A TGT byte of 8'hFF ends the session cleanly.
//
//   Optional feature: define UART_PROG_CSUM_EN to require one XOR checksum
//   byte after the last word of every frame with N>0.
//
// Ports
//   clock  in   system clock
//   reset  in   asynchronous, active-high
//   start  in   1-cycle pulse, begins a session (ignored while busy)
//   rx     in   UART serial input, idle high
//   wen    out  one-hot write strobe, one cycle per word
//   adr    out  word address of the current write (held between strobes)
//   dat    out  write data (held between strobes)
//   busy   out  session in progress
//   done   out  session ended cleanly (sticky until next start)
//   err    out  protocol/framing/timeout error (sticky until next start)
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 14,
  parameter int NUM_TGT      = 2,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               rx,
  output logic [NUM_TGT-1:0] wen,
  output logic [ADDR_W-1:0]  adr,
  output logic [DATA_W-1:0]  dat,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int BIT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int BPW      = DATA_W / 8;
  localparam int BI_W     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TGT_W    = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);
  // Largest word count that still fits the per-target address space.
  localparam logic [16:0] MAX_N = (ADDR_W >= 16) ? 17'h10000 : 17'(1 << ADDR_W);

  // ---------------------------------------------------------------------------
  // 8N1 receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_st;
  logic [2:0]       rx_sync;   // [0],[1] synchroniser, [2] previous synced value
  logic [BIT_W-1:0] bit_tmr;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_vld;
  logic             frame_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync   <= '1;
      rx_st     <= RX_IDLE;
      bit_tmr   <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[1:0], rx};
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_st)
        // Edge-triggered so a low stop bit cannot immediately re-arm the receiver.
        RX_IDLE: if (rx_sync[2] && !rx_sync[1]) begin
          rx_st   <= RX_START;
          bit_tmr <= '0;
        end
        // Half a bit in: line must still be low, otherwise it was a glitch.
        RX_START: if (bit_tmr == BIT_W'(HALF_BIT - 1)) begin
          bit_tmr <= '0;
          bit_idx <= '0;
          rx_st   <= rx_sync[1] ? RX_IDLE : RX_DATA;
        end else begin
          bit_tmr <= bit_tmr + BIT_W'(1);
        end
        RX_DATA: if (bit_tmr == BIT_W'(CLKS_PER_BIT - 1)) begin
          bit_tmr <= '0;
          rx_byte <= {rx_sync[1], rx_byte[7:1]};   // LSB first
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_st <= RX_STOP;
        end else begin
          bit_tmr <= bit_tmr + BIT_W'(1);
        end
        RX_STOP: if (bit_tmr == BIT_W'(CLKS_PER_BIT - 1)) begin
          bit_tmr   <= '0;
          rx_st     <= RX_IDLE;
          byte_vld  <= rx_sync[1];
          frame_err <= !rx_sync[1];
        end else begin
          bit_tmr <= bit_tmr + BIT_W'(1);
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE, S_TGT, S_CNT_LO, S_CNT_HI, S_DATA,
`ifdef UART_PROG_CSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [TGT_W-1:0]  tgt_q;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       last_idx_q;
  logic [15:0]       widx_q;
  logic [BI_W-1:0]   bidx_q;
  logic [DATA_W-1:0] word_q, word_nx;
  logic [TO_W-1:0]   idle_q;
  logic [15:0]       n_words;
  logic              tgt_ok, word_last, frame_last, timeout;
`ifdef UART_PROG_CSUM_EN
  logic [7:0]        csum_q;
`endif

  assign n_words    = {rx_byte, cnt_lo_q};
  assign tgt_ok     = int'({24'd0, rx_byte}) < NUM_TGT;
  assign word_last  = (bidx_q == BI_W'(BPW - 1));
  assign frame_last = word_last && (widx_q == last_idx_q);
  // A byte arriving this cycle restarts the idle window, so it can't time out.
  assign timeout    = busy && !byte_vld && (idle_q == TO_W'(TIMEOUT_CYC - 1));

  // Insert the incoming byte at its little-endian lane.
  always_comb begin
    word_nx = word_q;
    word_nx[8*bidx_q +: 8] = rx_byte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_TGT;
      S_TGT: if (byte_vld) begin
        if (tgt_ok)                 state_d = S_CNT_LO;
        else if (rx_byte == 8'hFF)  state_d = S_DONE;
        else                        state_d = S_ERR;
      end
      S_CNT_LO: if (byte_vld) state_d = S_CNT_HI;
      S_CNT_HI: if (byte_vld) begin
        if ({1'b0, n_words} > MAX_N) state_d = S_ERR;
        else if (n_words == 16'd0)   state_d = S_TGT;
        else                         state_d = S_DATA;
      end
`ifdef UART_PROG_CSUM_EN
      S_DATA: if (byte_vld && frame_last) state_d = S_CSUM;
      S_CSUM: if (byte_vld) state_d = (rx_byte == csum_q) ? S_TGT : S_ERR;
`else
      S_DATA: if (byte_vld && frame_last) state_d = S_TGT;
`endif
      default: state_d = S_IDLE;
    endcase
    if (busy && (frame_err || timeout)) state_d = S_ERR;
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    case (state_q)
      S_TGT, S_CNT_LO, S_CNT_HI, S_DATA: busy = 1'b1;
`ifdef UART_PROG_CSUM_EN
      S_CSUM: busy = 1'b1;
`endif
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: addressing, word assembly, write strobe, idle timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tgt_q      <= '0;
      cnt_lo_q   <= '0;
      last_idx_q <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      idle_q     <= '0;
      wen        <= '0;
      adr        <= '0;
      dat        <= '0;
`ifdef UART_PROG_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      wen <= '0;

      if (!busy || byte_vld)  idle_q <= '0;
      else if (!timeout)      idle_q <= idle_q + TO_W'(1);

      if (byte_vld) begin
        case (state_q)
          S_TGT: begin
            tgt_q <= rx_byte[TGT_W-1:0];
`ifdef UART_PROG_CSUM_EN
            csum_q <= '0;
`endif
          end
          S_CNT_LO: cnt_lo_q <= rx_byte;
          S_CNT_HI: begin
            last_idx_q <= n_words - 16'd1;
            widx_q     <= '0;
            bidx_q     <= '0;
          end
          S_DATA: begin
            word_q <= word_nx;
`ifdef UART_PROG_CSUM_EN
            csum_q <= csum_q ^ rx_byte;
`endif
            if (word_last) begin
              wen    <= NUM_TGT'(1) << tgt_q;
              adr    <= ADDR_W'(widx_q);
              dat    <= word_nx;
              widx_q <= widx_q + 16'd1;
              bidx_q <= '0;
            end else begin
              bidx_q <= bidx_q + BI_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader: byte-level host driver, a transaction-level
// frame model producing the expected writes and session outcome, and a
// per-cycle monitor comparing the write port against the model.
module tb_uart_prog_loader;

  localparam int CPB    = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int NTGT   = 2;
  localparam int TO_CYC = 200;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int                tgt;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wr_t;

  logic              clock, reset, start, rx;
  logic [NTGT-1:0]   wen;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat;
  logic              busy, done, err;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .NUM_TGT(NTGT), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .rx(rx),
    .wen(wen), .adr(adr), .dat(dat),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Byte k of a packed list is the k-th most significant of its n bytes.
  function automatic bq_t mkq(input logic [255:0] v, input int n);
    bq_t q;
    q = {};
    for (int k = 0; k < n; k++) q.push_back(v[8*(n-1-k) +: 8]);
    return q;
  endfunction

  // Frame model: walks the byte list, queues the writes it implies and
  // returns 0 = still in a session, 1 = done, 2 = error.
  function automatic int model_run(input bq_t b);
    int   i, t, n;
    logic [7:0] x;
    wr_t  e;
    i = 0;
    while (1) begin
      if (i >= b.size()) return 0;
      t = int'(b[i]); i++;
      if (t == 255) return 1;
      if (t >= NTGT) return 2;
      if (i + 2 > b.size()) return 0;
      n = int'(b[i]) + 256 * int'(b[i+1]); i += 2;
      if (n > (1 << ADDR_W)) return 2;
      x = 8'h00;
      for (int w = 0; w < n; w++) begin
        if (i + 4 > b.size()) return 0;
        e.tgt = t;
        e.adr = ADDR_W'(w);
        e.dat = {b[i+3], b[i+2], b[i+1], b[i]};
        x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
        exp_q.push_back(e);
        i += 4;
      end
`ifdef UART_PROG_CSUM_EN
      if (n > 0) begin
        if (i >= b.size()) return 0;
        if (b[i] != x) return 2;
        i++;
      end
`endif
    end
    return 0;
  endfunction

  task automatic rx_drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx_drive(1'b0, CPB);
    for (int k = 0; k < 8; k++) rx_drive(b[k], CPB);
    rx_drive(stop_ok, CPB);
    rx_drive(1'b1, 2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_end(input int o, input string nm);
    int k;
    k = 0;
    while (!(done || err) && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk({nm, "_done"}, done, o == 1);
    chk({nm, "_err"}, err, o == 2);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic run_session(input bq_t b, input int o, input string nm);
    pulse_start();
    foreach (b[k]) send_byte(b[k], 1'b1);
    wait_end(o, nm);
  endtask

  // Checks every write against the model; outside strobes adr/dat must hold.
  task automatic monitor();
    wr_t               e;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pa = '0;
        pd = '0;
      end else begin
        chk("wen_onehot", $countones(wen) <= 1, 1);
        chk("status_exclusive", (int'(busy) + int'(done) + int'(err)) <= 1, 1);
        if (wen != '0) begin
          if (exp_q.size() == 0) chk("unexpected_wen", wen, 0);
          else begin
            e = exp_q.pop_front();
            chk("wen_tgt", wen, 2'b01 << e.tgt);
            chk("wr_adr", adr, e.adr);
            chk("wr_dat", dat, e.dat);
          end
        end else begin
          chk("adr_hold", adr, pa);
          chk("dat_hold", dat, pd);
        end
        pa = adr;
        pd = dat;
      end
    end
  endtask

  task automatic watchdog();
    repeat (95000) @(negedge clock);
    $display("FAIL watchdog: cycle budget exhausted, got running expected finished");
    $fatal(1, "bench stopped by watchdog");
  endtask

  initial begin
    bq_t        b;
    int         o, k, nf, t, n;
    logic [7:0] d, x;

    clock = 1'b0; reset = 1'b1; start = 1'b0; rx = 1'b1;
    fork
      monitor();
      watchdog();
    join_none

    repeat (3) @(negedge clock);
    chk("rst_wen", wen, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: two words into target 0
    b = mkq(256'h00_0200_78563412_EFBEADDE_FF, 12);
    o = model_run(b);
    chk("model_t1_out", o, 1);
    chk("model_t1_n", exp_q.size(), 2);
    chk("model_t1_dat0", exp_q[0].dat, 32'h12345678);
    chk("model_t1_adr1", exp_q[1].adr, 1);
    chk("model_t1_dat1", exp_q[1].dat, 32'hDEADBEEF);
    run_session(b, o, "t1");

    // 2: empty frame, then one word into target 1
    b = mkq(256'h01_0000_01_0100_AABBCCDD_FF, 11);
    o = model_run(b);
    chk("model_t2_n", exp_q.size(), 1);
    chk("model_t2_tgt", exp_q[0].tgt, 1);
    chk("model_t2_dat", exp_q[0].dat, 32'hDDCCBBAA);
    run_session(b, o, "t2");

    // 3: bad target, then a clean restart from ERR
    b = mkq(256'h05, 1);
    o = model_run(b);
    chk("model_t3_out", o, 2);
    run_session(b, o, "t3a");
    b = mkq(256'hFF, 1);
    o = model_run(b);
    run_session(b, o, "t3b");

    // Boundaries: target == NUM_TGT, count 2**ADDR_W+1
    b = mkq(256'h02, 1);
    run_session(b, model_run(b), "tgt_eq_num");
    b = mkq(256'h00_0140, 3);
    o = model_run(b);
    chk("model_bigN_out", o, 2);
    run_session(b, o, "big_n");

    // 4a: framing error on the second byte
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b0);
    wait_end(2, "t4_ferr");

    // 4b: one-cycle glitch and a start pulse mid-session are both ignored
    b = mkq(256'h00_0100_A1B2C3D4_FF, 8);
    o = model_run(b);
    pulse_start();
    send_byte(b[0], 1'b1);
    start = 1'b1; @(negedge clock); start = 1'b0;
    rx = 1'b0; @(negedge clock); rx = 1'b1;
    repeat (8) @(negedge clock);
    chk("t4_glitch_err", err, 0);
    chk("t4_glitch_busy", busy, 1);
    for (int i = 1; i < b.size(); i++) send_byte(b[i], 1'b1);
    wait_end(o, "t4_glitch");

    // 5: partial word then stall until timeout
    b = mkq(256'h00_0100_1122, 5);
    o = model_run(b);
    chk("model_t5_out", o, 0);
    pulse_start();
    foreach (b[i]) send_byte(b[i], 1'b1);
    repeat (170) @(negedge clock);
    chk("t5_early_err", err, 0);
    chk("t5_early_busy", busy, 1);
    k = 0;
    while (!err && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("t5_timeout_err", err, 1);
    chk("t5_timeout_busy", busy, 0);
    chk("t5_writes_left", exp_q.size(), 0);

    // 5b: reset in the middle of the second word
    b = mkq(256'h00_0200_11223344_5566, 9);
    o = model_run(b);
    pulse_start();
    foreach (b[i]) send_byte(b[i], 1'b1);
    rx_drive(1'b0, 6);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wen", wen, 0);
    chk("mid_rst_adr", adr, 0);
    chk("mid_rst_dat", dat, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_writes_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (60) @(negedge clock);
    chk("post_rst_busy", busy, 0);

`ifdef UART_PROG_CSUM_EN
    // 6: checksum good, then bad
    b = mkq(256'h00_0100_01020408_0F_FF, 9);
    o = model_run(b);
    chk("model_t6a_out", o, 1);
    run_session(b, o, "t6_good");
    b = mkq(256'h00_0100_01020408_0E_FF, 9);
    o = model_run(b);
    chk("model_t6b_out", o, 2);
    chk("model_t6b_n", exp_q.size(), 1);
    run_session(b, o, "t6_bad");
`endif

    // Randomised sessions
    for (int s = 0; s < 8; s++) begin
      b = {};
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 9) == 0) begin
          b.push_back(8'($urandom_range(2, 254)));
          break;
        end
        t = $urandom_range(0, 1);
        n = $urandom_range(0, 3);
        b.push_back(8'(t));
        b.push_back(8'(n));
        b.push_back(8'h00);
        x = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          d = 8'($urandom);
          b.push_back(d);
          x = x ^ d;
        end
`ifdef UART_PROG_CSUM_EN
        if (n > 0) b.push_back(x);
`endif
      end
      b.push_back(8'hFF);
      o = model_run(b);
      run_session(b, o, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
